// File: rtl/frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and its environment
// (VGA timing, update clients, status consumers).
interface frame_scheduler_if #(
    parameter int N_CLIENTS = 4
);
    logic                 new_frame;
    logic                 enable;
    logic [N_CLIENTS-1:0] client_en;
    logic [N_CLIENTS-1:0] done;
    logic                 clear_err;
    logic [N_CLIENTS-1:0] start;
    logic                 busy;
    logic                 frame_done;
    logic [15:0]          frame_count;
    logic                 overrun;
    logic [N_CLIENTS-1:0] timeout_err;

    // Scheduler side
    modport master (
        input  new_frame, enable, client_en, done, clear_err,
        output start, busy, frame_done, frame_count, overrun, timeout_err
    );

    // Environment side
    modport slave (
        output new_frame, enable, client_en, done, clear_err,
        input  start, busy, frame_done, frame_count, overrun, timeout_err
    );
endinterface

// File: rtl/frame_scheduler.sv
// Per-frame update sequencer: on each accepted new_frame, grants the update
// window to each enabled client in index order, one start pulse per client,
// until the client reports done or its watchdog expires.
module frame_scheduler #(
    parameter int N_CLIENTS = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    frame_scheduler_if.master bus
);
    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]        CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [N_CLIENTS-1:0] ONE      = N_CLIENTS'(1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t               state;
    logic [N_CLIENTS-1:0] en_q;
    logic [IW-1:0]        idx;
    logic [CW-1:0]        cnt;

    logic                 first_found;
    logic [IW-1:0]        first_idx;
    logic                 next_found;
    logic [IW-1:0]        next_idx;
    logic                 cur_done;
    logic                 expired;
    logic                 slot_end;
    logic                 ov_set;
    logic [N_CLIENTS-1:0] to_set;

    // Lowest enabled client in the incoming mask (first client of a frame).
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int unsigned i = N_CLIENTS; i > 0; i--) begin
            if (bus.client_en[i-1]) begin
                first_found = 1'b1;
                first_idx   = IW'(i - 1);
            end
        end
    end

    // Lowest latched client strictly above the current one (next slot owner).
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int unsigned i = N_CLIENTS; i > 0; i--) begin
            if (en_q[i-1] && ((i - 1) > 32'(idx))) begin
                next_found = 1'b1;
                next_idx   = IW'(i - 1);
            end
        end
    end

    // Slot termination and sticky-flag set conditions.
    always_comb begin
        cur_done = (state == WAIT) && bus.done[idx];
        expired  = (state == WAIT) && (cnt == CNT_LAST);
        slot_end = cur_done || expired;
        ov_set   = bus.new_frame && (state != IDLE);
        to_set   = (expired && !cur_done) ? (ONE << idx) : '0;
    end

    // Sequencer FSM with registered outputs and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            en_q            <= '0;
            idx             <= '0;
            cnt             <= '0;
            bus.start       <= '0;
            bus.busy        <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.frame_count <= '0;
            bus.overrun     <= 1'b0;
            bus.timeout_err <= '0;
        end else begin
            bus.start      <= '0;
            bus.frame_done <= 1'b0;

            // A set event in the same cycle as clear_err keeps the flag high.
            if (ov_set)
                bus.overrun <= 1'b1;
            else if (bus.clear_err)
                bus.overrun <= 1'b0;
            bus.timeout_err <= (bus.timeout_err & ~{N_CLIENTS{bus.clear_err}}) | to_set;

            case (state)
                IDLE: begin
                    if (bus.new_frame && bus.enable) begin
                        en_q <= bus.client_en;
                        if (first_found) begin
                            state     <= START;
                            idx       <= first_idx;
                            bus.start <= ONE << first_idx;
                            bus.busy  <= 1'b1;
                        end else begin
                            bus.frame_done  <= 1'b1;
                            bus.frame_count <= bus.frame_count + 16'd1;
                        end
                    end
                end
                START: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (slot_end) begin
                        if (next_found) begin
                            state     <= START;
                            idx       <= next_idx;
                            bus.start <= ONE << next_idx;
                        end else begin
                            state           <= IDLE;
                            bus.busy        <= 1'b0;
                            bus.frame_done  <= 1'b1;
                            bus.frame_count <= bus.frame_count + 16'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
